// File: rtl/video_fetch_buf.sv
// video_fetch_buf
//   Buffers 16-bit DRAM read words for the video fetch window and merges them
//   into the 32-bit renderer word fetch_data, one word per fetch_stb, using the
//   per-mode byte-lane selects. Requests are only raised while every word in
//   flight is guaranteed a FIFO slot; line_start_s flushes stale data and arms
//   a discard count so words already requested before the flush are dropped.
//
// Ports
//   clk, res          : clock, synchronous active-high reset
//   fetch_en          : fetch window active, gates video_req
//   video_req         : request a DRAM read for the next word
//   video_next        : arbiter accepted the request this cycle
//   video_strobe      : DRAM read data valid this cycle
//   dram_rdata[15:0]  : DRAM read data
//   fetch_stb         : renderer pop/merge strobe
//   fetch_sel[3:0]    : byte-lane write enables for fetch_data
//   fetch_bsl[1:0]    : byte source select (2'b10 pass-through, else bsl[0] hi/lo)
//   line_start_s      : line start, flushes FIFO and clears sticky flags
//   fetch_data[31:0]  : merged renderer word
//   level             : FIFO occupancy in words
//   empty, full       : FIFO status
//   overflow, underflow : sticky error flags
module video_fetch_buf #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     fetch_en,
  output logic                     video_req,
  input  logic                     video_next,
  input  logic                     video_strobe,
  input  logic [15:0]              dram_rdata,
  input  logic                     fetch_stb,
  input  logic [3:0]               fetch_sel,
  input  logic [1:0]               fetch_bsl,
  input  logic                     line_start_s,
  output logic [31:0]              fetch_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = AW + 2;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] pending;
  logic [LW-1:0] pending_nxt;
  logic [LW-1:0] discard;
  logic [SW-1:0] committed;

  logic inc;
  logic dec;
  logic drop_strobe;
  logic push_req;
  logic pop_req;
  logic do_push;
  logic do_pop;

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [15:0] w,
                                              input logic [3:0]  sel,
                                              input logic [1:0]  bsl);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        if (bsl == 2'b10)
          r[8*i +: 8] = w[8*(i%2) +: 8];
        else if (bsl[0])
          r[8*i +: 8] = w[15:8];
        else
          r[8*i +: 8] = w[7:0];
      end
    end
    return r;
  endfunction

  // Words held plus words still coming back; the extra bit keeps the sum from wrapping.
  assign committed = SW'(level) + SW'(pending);
  assign video_req = ~res & fetch_en & (committed < SW'(DEPTH));

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  assign inc = video_next & video_req;
  assign dec = video_strobe;

  // A stray strobe with nothing outstanding (e.g. straight after reset)
  // must not wrap the counter.
  always_comb begin
    pending_nxt = pending;
    if (inc && !dec)
      pending_nxt = pending + LW'(1);
    else if (dec && !inc && pending != '0)
      pending_nxt = pending - LW'(1);
  end

  assign drop_strobe = video_strobe & (discard != '0);
  assign push_req    = video_strobe & ~drop_strobe & ~line_start_s;
  assign pop_req     = fetch_stb & ~line_start_s;
  assign do_pop      = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_push     = push_req & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      pending    <= '0;
      discard    <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      fetch_data <= '0;
    end else begin
      pending <= pending_nxt;
      if (line_start_s) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        // Everything still outstanding belongs to the previous line.
        discard   <= pending_nxt;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (drop_strobe)
          discard <= discard - LW'(1);
        if (do_push)
          wr_ptr <= wr_ptr + AW'(1);
        if (do_pop) begin
          rd_ptr     <= rd_ptr + AW'(1);
          fetch_data <= merge_lanes(fetch_data, mem[rd_ptr], fetch_sel, fetch_bsl);
        end
        if (do_push && !do_pop)
          level <= level + LW'(1);
        else if (do_pop && !do_push)
          level <= level - LW'(1);
        if (push_req && !do_push)
          overflow <= 1'b1;
        if (pop_req && empty)
          underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= dram_rdata;
  end

endmodule

// File: tb/tb_video_fetch_buf.sv
module tb_video_fetch_buf;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        res;
  logic        fetch_en;
  logic        video_req;
  logic        video_next;
  logic        video_strobe;
  logic [15:0] dram_rdata;
  logic        fetch_stb;
  logic [3:0]  fetch_sel;
  logic [1:0]  fetch_bsl;
  logic        line_start_s;
  logic [31:0] fetch_data;
  logic [3:0]  level;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  always #5 clk = ~clk;

  video_fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .res          (res),
    .fetch_en     (fetch_en),
    .video_req    (video_req),
    .video_next   (video_next),
    .video_strobe (video_strobe),
    .dram_rdata   (dram_rdata),
    .fetch_stb    (fetch_stb),
    .fetch_sel    (fetch_sel),
    .fetch_bsl    (fetch_bsl),
    .line_start_s (line_start_s),
    .fetch_data   (fetch_data),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO as a queue, counters as plain integers.
  logic [15:0] mq[$];
  int          m_pend  = 0;
  int          m_disc  = 0;
  logic [31:0] m_data  = '0;
  bit          m_ovf   = 0;
  bit          m_unf   = 0;
  int          accepts = 0;

  bit chk_on = 0;
  int cyc    = 0;
  int wcnt   = 0;
  int due[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_req();
    return !res && fetch_en && ((mq.size() + m_pend) < DEPTH);
  endfunction

  function automatic logic [31:0] tb_merge(input logic [31:0] cur, input logic [15:0] w,
                                           input logic [3:0] sel, input logic [1:0] bsl);
    logic [31:0] r;
    logic [7:0]  b;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (bsl == 2'b10) b = (i % 2 == 1) ? w[15:8] : w[7:0];
      else              b = bsl[0] ? w[15:8] : w[7:0];
      if (sel[i]) r[8*i +: 8] = b;
    end
    return r;
  endfunction

  task automatic model_update();
    int          np;
    bit          inc;
    bit          push_ok;
    logic [15:0] w;
    if (res) begin
      mq.delete();
      m_pend = 0; m_disc = 0; m_data = '0; m_ovf = 0; m_unf = 0;
      return;
    end
    inc = video_next && m_req();
    np  = m_pend + (inc ? 1 : 0) - (video_strobe ? 1 : 0);
    if (np < 0) np = 0;
    if (line_start_s) begin
      mq.delete();
      m_disc = np;
      m_ovf  = 0;
      m_unf  = 0;
    end else begin
      push_ok = 0;
      if (video_strobe) begin
        if (m_disc > 0) m_disc--;
        else            push_ok = 1;
      end
      if (fetch_stb) begin
        if (mq.size() == 0) m_unf = 1;
        else begin
          w = mq.pop_front();
          m_data = tb_merge(m_data, w, fetch_sel, fetch_bsl);
        end
      end
      if (push_ok) begin
        if (mq.size() < DEPTH) mq.push_back(dram_rdata);
        else                   m_ovf = 1;
      end
    end
    m_pend = np;
    if (inc) accepts++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
    cyc++;
  endtask

  // Arbiter/DRAM stand-in: in-order returns after a latency per accepted request.
  task automatic arb_drive(input int p_next, input int lat_min, input int lat_max, input bit rnd);
    video_next = m_req() && ($urandom_range(99) < p_next);
    if (video_next) due.push_back(cyc + $urandom_range(lat_max, lat_min));
    video_strobe = (due.size() > 0) && (due[0] <= cyc);
    if (video_strobe) begin
      void'(due.pop_front());
      dram_rdata = rnd ? 16'($urandom) : (16'h0100 + 16'(wcnt));
      wcnt++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("level",     32'(level),      32'(mq.size()));
        check("empty",     32'(empty),      32'(mq.size() == 0));
        check("full",      32'(full),       32'(mq.size() == DEPTH));
        check("overflow",  32'(overflow),   32'(m_ovf));
        check("underflow", 32'(underflow),  32'(m_unf));
        check("fetch_data", fetch_data,     m_data);
        check("video_req", 32'(video_req),  32'(m_req()));
      end
    end
  end

  initial begin
    res = 1'b1; fetch_en = 1'b1; video_next = 1'b0; video_strobe = 1'b0;
    dram_rdata = '0; fetch_stb = 1'b0; fetch_sel = '0; fetch_bsl = '0;
    line_start_s = 1'b0;

    // Reset state
    tick();
    check("req_in_reset", 32'(video_req), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_data", fetch_data, 32'h0);
    res = 1'b0; fetch_en = 1'b0;
    chk_on = 1;
    tick();

    // Pass-through of a full word into the low half
    video_strobe = 1'b1; dram_rdata = 16'h1234; tick(); video_strobe = 1'b0;
    check("push_level", 32'(level), 32'd1);
    fetch_stb = 1'b1; fetch_sel = 4'b0011; fetch_bsl = 2'b10; tick(); fetch_stb = 1'b0;
    check("pass_data", fetch_data, 32'h0000_1234);
    check("pop_level", 32'(level), 32'd0);

    // High byte, then low byte into lane 0
    video_strobe = 1'b1; dram_rdata = 16'hABCD; tick(); video_strobe = 1'b0;
    fetch_stb = 1'b1; fetch_sel = 4'b0001; fetch_bsl = 2'b11; tick(); fetch_stb = 1'b0;
    check("hi_byte", fetch_data, 32'h0000_12AB);
    video_strobe = 1'b1; dram_rdata = 16'hABCD; tick(); video_strobe = 1'b0;
    fetch_stb = 1'b1; fetch_bsl = 2'b00; tick(); fetch_stb = 1'b0;
    check("lo_byte", fetch_data, 32'h0000_12CD);

    // Underflow sticks until line start
    fetch_stb = 1'b1; fetch_sel = 4'b1111; tick(); fetch_stb = 1'b0;
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_hold", fetch_data, 32'h0000_12CD);
    line_start_s = 1'b1; tick(); line_start_s = 1'b0;
    check("unf_clr", 32'(underflow), 32'd0);

    // Line start discards words still in flight
    fetch_en = 1'b1; video_next = 1'b1;
    repeat (5) tick();
    fetch_en = 1'b0; video_next = 1'b0;
    video_strobe = 1'b1; dram_rdata = 16'h0001; tick();
    dram_rdata = 16'h0002; tick(); video_strobe = 1'b0;
    check("pre_flush_level", 32'(level), 32'd2);
    line_start_s = 1'b1; tick(); line_start_s = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    video_strobe = 1'b1;
    dram_rdata = 16'h0011; tick();
    dram_rdata = 16'h0022; tick();
    dram_rdata = 16'h0033; tick();
    check("discard_level", 32'(level), 32'd0);
    dram_rdata = 16'h0044; tick(); video_strobe = 1'b0;
    check("after_discard_level", 32'(level), 32'd1);
    fetch_stb = 1'b1; fetch_sel = 4'b1111; fetch_bsl = 2'b10; tick(); fetch_stb = 1'b0;
    check("after_discard_data", fetch_data, 32'h0044_0044);

    // Fill: next tied to req, data back 3 cycles later
    accepts = 0; wcnt = 0; fetch_en = 1'b1;
    repeat (30) begin
      arb_drive(100, 3, 3, 1'b0);
      tick();
    end
    fetch_en = 1'b0; video_next = 1'b0; video_strobe = 1'b0;
    check("fill_accepts", 32'(accepts), 32'd8);
    check("fill_level", 32'(level), 32'd8);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);

    // Push and pop together at full
    video_strobe = 1'b1; dram_rdata = 16'hBEEF;
    fetch_stb = 1'b1; fetch_sel = 4'b0011; fetch_bsl = 2'b10; tick();
    video_strobe = 1'b0; fetch_stb = 1'b0;
    check("full_pp_level", 32'(level), 32'd8);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_data", fetch_data, 32'h0044_0100);
    fetch_stb = 1'b1; repeat (8) tick(); fetch_stb = 1'b0;
    check("full_pp_last", fetch_data, 32'h0044_BEEF);
    check("drain_empty", 32'(empty), 32'd1);

    // Randomized traffic with occasional line starts and resets
    due.delete();
    for (int n = 0; n < 3000; n++) begin
      res          = ($urandom_range(199) == 0);
      line_start_s = !res && ($urandom_range(49) == 0);
      fetch_en     = ($urandom_range(9) < 8);
      fetch_stb    = ($urandom_range(9) < 4);
      fetch_sel    = 4'($urandom);
      fetch_bsl    = 2'($urandom);
      if (res) begin
        due.delete();
        video_next   = 1'b0;
        video_strobe = 1'b0;
      end else begin
        arb_drive(70, 1, 6, 1'b1);
      end
      tick();
    end
    res = 1'b0; line_start_s = 1'b0; fetch_en = 1'b0; fetch_stb = 1'b0;
    video_next = 1'b0; video_strobe = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
